// File: rtl/ctrl_pipe.sv
// Control-side pipeline registers EX/MEM/WB, with load-use stall, taken-branch flush
// and EX-stage operand forwarding select generation.
module ctrl_pipe (
    input  logic        clk,
    input  logic        reset,
    input  logic [17:0] id_ctrl,
    input  logic        id_valid,
    input  logic [3:0]  id_rd,
    input  logic [3:0]  id_rs_a,
    input  logic [3:0]  id_rs_b,
    input  logic        id_use_a,
    input  logic        id_use_b,
    output logic [17:0] ex_ctrl,
    output logic [17:0] mem_ctrl,
    output logic [17:0] wb_ctrl,
    output logic [3:0]  mem_dst,
    output logic [3:0]  wb_dst,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall,
    output logic        flush
);

    localparam int unsigned BR_BIT    = 17;
    localparam int unsigned MREAD_BIT = 15;
    localparam int unsigned RW_BIT    = 14;
    localparam int unsigned RDST_BIT  = 13;

    localparam logic [3:0] LR_REG = 4'd14;
    localparam logic [3:0] PC_REG = 4'd15;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic [17:0] id_clean;
    logic [3:0]  id_dst;
    logic [3:0]  ex_dst;
    logic [3:0]  ex_rs_a;
    logic [3:0]  ex_rs_b;
    logic        ex_use_a;
    logic        ex_use_b;
    logic        load_use;
    logic        ex_kill;

    // Don't-care fields may arrive as X; only a definite 1 is kept.
    always_comb begin
        id_clean = '0;
        for (int unsigned i = 0; i < 18; i++) begin
            id_clean[i] = (id_ctrl[i] === 1'b1);
        end
    end

    assign id_dst = id_clean[RDST_BIT] ? LR_REG : id_rd;

    assign load_use = ex_ctrl[MREAD_BIT] & ex_ctrl[RW_BIT] & id_valid &
                      ((id_use_a & (id_rs_a == ex_dst)) |
                       (id_use_b & (id_rs_b == ex_dst)));

    // A taken branch wins over a load-use stall; the ID instruction is wrong-path anyway.
    assign flush   = ex_ctrl[BR_BIT];
    assign stall   = load_use & ~flush;
    assign ex_kill = flush | stall | ~id_valid;

    function automatic logic [1:0] fwd_sel(
        input logic        use_src,
        input logic [3:0]  rs,
        input logic [17:0] m_ctrl,
        input logic [3:0]  m_dst,
        input logic [17:0] w_ctrl,
        input logic [3:0]  w_dst
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_src && (rs != PC_REG)) begin
            if (m_ctrl[RW_BIT] && !m_ctrl[MREAD_BIT] && (m_dst == rs)) begin
                sel = FWD_MEM;
            end else if (w_ctrl[RW_BIT] && (w_dst == rs)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(ex_use_a, ex_rs_a, mem_ctrl, mem_dst, wb_ctrl, wb_dst);
    assign fwd_b = fwd_sel(ex_use_b, ex_rs_b, mem_ctrl, mem_dst, wb_ctrl, wb_dst);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_ctrl  <= '0;
            ex_dst   <= '0;
            ex_rs_a  <= '0;
            ex_rs_b  <= '0;
            ex_use_a <= 1'b0;
            ex_use_b <= 1'b0;
            mem_ctrl <= '0;
            mem_dst  <= '0;
            wb_ctrl  <= '0;
            wb_dst   <= '0;
        end else begin
            if (ex_kill) begin
                ex_ctrl  <= '0;
                ex_dst   <= '0;
                ex_rs_a  <= '0;
                ex_rs_b  <= '0;
                ex_use_a <= 1'b0;
                ex_use_b <= 1'b0;
            end else begin
                ex_ctrl  <= id_clean;
                ex_dst   <= id_dst;
                ex_rs_a  <= id_rs_a;
                ex_rs_b  <= id_rs_b;
                ex_use_a <= id_use_a;
                ex_use_b <= id_use_b;
            end
            mem_ctrl <= ex_ctrl;
            mem_dst  <= ex_dst;
            wb_ctrl  <= mem_ctrl;
            wb_dst   <= mem_dst;
        end
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the 18-bit control bundle produced by the decode-stage control decoder through the EX, MEM and WB pipeline registers. It is the consumer end of that control interface. It also detects load-use hazards, squashes wrong-path instructions when a branch is taken, and generates the EX-stage operand forwarding selects. It sits beside the datapath pipeline registers and drives the PC/IF-ID hold and kill signals.

## Interface
- Parameters: none. Bundle layout is fixed: [17] branch, [16] Mwrite, [15] Mread, [14] regwrite, [13] regdst, [12:10] regsrc, [9] ALUsrcA, [8] ALUsrcB, [7:4] ALUop, [3] NZCVwrite, [2:1] immsrc, [0] regbdst.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  pipeline clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `id_ctrl`  in  18  decoded control bundle for the instruction in ID. X allowed only in don't-care fields.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rd`  in  4  destination register field of the ID instruction.
- `id_rs_a` / `id_rs_b`  in  4 each  source register numbers of the ID instruction.
- `id_use_a` / `id_use_b`  in  1 each  ID instruction reads that source.
- `ex_ctrl`, `mem_ctrl`, `wb_ctrl`  out  18 each  registered bundle per stage.
- `mem_dst`, `wb_dst`  out  4 each  registered destination register.
- `fwd_a`, `fwd_b`  out  2 each  EX operand select: 00 register file, 01 MEM ALU result, 10 WB result, 11 unused.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `flush`  out  1  kill the IF/ID contents this cycle.

## Operation
- Bubble: an all-zero bundle, dst 0, use flags 0. A bubble never writes memory, registers or NZCV and never branches.
- ID destination: id_dst = 14 (LR) when id_ctrl[13]=1, else id_rd.
- EX register (ctrl, dst, rs_a, rs_b, use flags) loads a bubble when reset, flush, stall or !id_valid. Otherwise it loads the ID values, with X bits in id_ctrl forced to 0.
- MEM register loads from EX every cycle. WB register loads from MEM every cycle. Neither register is affected by stall or flush.
- Load-use hazard, combinational from EX register and ID inputs:
  - Condition: ex_ctrl[15] & ex_ctrl[14] & ((id_use_a & id_rs_a==ex_dst) | (id_use_b & id_rs_b==ex_dst)) & id_valid.
  - When the condition holds: stall=1.
- Branch taken: the EX bundle has ex_ctrl[17]=1. The condition is already folded in by the decoder. Then flush=1 and stall=0.
- Priority: flush overrides stall. A simultaneous taken branch and load-use gives flush=1, stall=0, and a bubble in EX.
- Forwarding for operand A (B is identical, using rs_b/use_b):
  - If ex_use_a & ex_rs_a!=15 & mem_ctrl[14] & !mem_ctrl[15] & mem_dst==ex_rs_a, then fwd_a=01.
  - Else if ex_use_a & ex_rs_a!=15 & wb_ctrl[14] & wb_dst==ex_rs_a, then fwd_a=10.
  - Else fwd_a=00.
  - MEM takes priority over WB.
  - A load in MEM never forwards. The stall guarantees it has reached WB before the consumer reaches EX.

## Timing
- Reset values: ex_ctrl, mem_ctrl, wb_ctrl = 0; mem_dst, wb_dst = 0; fwd_a, fwd_b = 00; stall = 0; flush = 0.
- Reset is asserted for one cycle; all three stage registers are bubbles after that edge.
- Latency: ID→EX 1 cycle, EX→MEM 1 cycle, MEM→WB 1 cycle.
- stall, flush and fwd_* are combinational from current register state and ID inputs, valid in the same cycle.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MEM, so the stall condition is false and the consumer enters EX. The cycle after, the consumer gets fwd=10.
- A taken branch in EX gives one flush cycle: the ID instruction becomes a bubble in EX.
- The branch advances to MEM normally, so a BL's regwrite to LR still reaches WB.
- The IF-stage instruction is killed by the datapath using the flush signal.
- Back-to-back branches: the second branch is already bubbled by the first flush, so no second flush occurs.
- Reset mid-stall or mid-flush: all stages become bubbles and stall/flush drop in the cycle after reset.

## Test plan
- Reset, then the ALU sequence ADD r1 ← …; ADD r2 ← r1 back-to-back → no stall, consumer in EX sees fwd_a=01. A third instruction reading r1 two slots later sees fwd_a=10.
- LDR r3 followed by ADD using r3 as operand B → stall=1 for exactly one cycle, bubble (ex_ctrl=0) in EX. The ADD then sees fwd_b=10.
- BL taken in EX → flush=1 one cycle, the ID instruction does not appear in EX, and mem_dst=14 then wb_dst=14 with wb_ctrl[14]=1.
- LDR r5 in EX, taken B in EX the next cycle while ID reads r5 → flush=1, stall=0, EX holds a bubble.
- Source r15 matching mem_dst=15 with regwrite → fwd stays 00. id_valid=0 with a nonzero id_ctrl → EX loads a bubble.
- Assert reset while a stall is active → the next cycle all three ctrl outputs are 0 and stall=0, flush=0.
